pybitseq: RTL and testbench
===========================

# pybitseq

TX payload bit sequencer, directly downstream of the packet-type decoder. It takes the decoded payload attributes (bit length, CRC enable, FEC 1/3 or 2/3 enable) and steps through the payload one air bit per bit strobe. For each air bit it tells the datapath which source to drive (payload buffer, CRC register, zero pad or FEC parity) and when to advance that source. It signals completion with a one-cycle pulse.

## Interface
- No parameters.
- clk_6M  in  1  6 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- start_p  in  1  one-cycle pulse; latch config and begin payload
- abort_p  in  1  one-cycle pulse; drop current payload
- bit_p  in  1  air-bit strobe, at most one per cycle
- pylenbit  in  13  payload data bits including payload header
- crcencode  in  1  append 16-bit CRC after data
- fec31encode  in  1  rate-1/3 repetition
- fec32encode  in  1  rate-2/3 shortened Hamming framing
- busy  out  1  sequencer active (state not IDLE)
- src_sel  out  2  source of the current air bit: 0 data, 1 CRC, 2 zero pad, 3 parity
- data_rd_p  out  1  advance payload buffer
- crc_shift_p  out  1  shift CRC register out
- par_shift_p  out  1  shift FEC parity register out
- done_p  out  1  payload complete
- airbitcnt  out  15  air bits emitted since start_p

## Operation
- States: IDLE, DATA, CRC, PAD, PARITY, FIN.
- start_p captures all config inputs into registers. The captured values are used until the next start_p; later input changes are ignored.
- On start_p:
  - If pylenbit == 0: go to FIN (CRC and FEC are ignored).
  - Otherwise: go to DATA.
  - Clear all counters.
- If fec31encode and fec32encode are both set, fec31 takes precedence.
- Info bits are the data bits followed by the CRC bits (16 if crcencode, else 0).
- No FEC: one air bit per info bit. Sequence is DATA (L bits), then CRC (16 bits if enabled), then FIN.
- fec31:
  - Each info bit occupies 3 air bits; repcnt counts 0..2.
  - data_rd_p and crc_shift_p fire only on the bit_p where repcnt == 2.
  - PAD and PARITY are never entered.
- fec32:
  - blkcnt counts info bits 0..9. On the bit_p where blkcnt == 9, go to PARITY for 5 air bits, then return to DATA, CRC or FIN as appropriate.
  - When info bits are exhausted with blkcnt != 0, go to PAD and emit zeros until blkcnt wraps, then PARITY, then FIN.
  - When exhausted exactly at a block boundary, go to PARITY, then FIN; no PAD.
- Strobes are combinational: (bit_p) & (src_sel matches) & (last repetition where applicable). par_shift_p = bit_p & PARITY.
- src_sel is valid while busy; it is 0 when idle.
- FIN: assert done_p for one cycle, then go to IDLE.
- abort_p: go to IDLE next cycle. No done_p, strobes go low, airbitcnt is held.
- Priority: rst > abort_p > start_p > bit_p.
  - start_p while busy restarts the sequence.
  - A bit_p in the same cycle as start_p or abort_p is ignored.

## Timing
- Reset values: state IDLE, busy 0, src_sel 0, all strobes 0, done_p 0, airbitcnt 0, all counters 0.
- start_p in cycle N: busy = 1 from N+1. The first bit_p is accepted from N+1.
- Counters and state update on the clock edge of the accepted bit_p. src_sel for the next air bit is valid the following cycle.
- done_p is asserted in the cycle after the edge that consumed the last air bit. busy falls in the cycle after done_p.
- pylenbit == 0: done_p is asserted in N+1 and busy is 0 from N+2.
- Air-bit totals (L = pylenbit, I = L + 16*crcencode):
  - No FEC: I.
  - fec31: 3·I.
  - fec32: 15·ceil(I/10).
- Counter widths: maximum is 3·(8191+16) = 24621, so airbitcnt needs 15 bits. It does not wrap in legal use.

## Test plan
- DM1-like (pylenbit 144, crc, fec32): 240 air bits → 144 data_rd_p, 16 crc_shift_p, 80 par_shift_p, 0 pad; done_p once; airbitcnt 240.
- Short fec32 (pylenbit 8, crc): 24 info bits → 3 blocks; 6 pad bits before the last parity group; 45 air bits; done_p once.
- HV1-like (pylenbit 80, fec31, no crc): 240 air bits; 80 data_rd_p, each on every third bit_p; src_sel never 2 or 3.
- NULL (pylenbit 0, crc set): done_p in cycle N+1; no strobes; airbitcnt 0; busy 0 by N+2.
- DH1-like (pylenbit 224, crc, no FEC) with abort_p after the 100th bit_p: IDLE next cycle; no done_p; airbitcnt holds 100. A following start_p restarts from 0 and completes with 240 air bits.
- Simultaneous events: start_p with bit_p → that bit is ignored and airbitcnt is 0. start_p mid-payload → restart with the new config. abort_p with start_p → IDLE.

Source files
------------

// File: rtl/pybitseq.sv
// TX payload bit sequencer: walks data, CRC, zero pad and FEC parity air bits
// one bit_p at a time and tells the datapath which source to advance.
module pybitseq (
   input  logic        clk_6M,
   input  logic        rst,
   input  logic        start_p,
   input  logic        abort_p,
   input  logic        bit_p,
   input  logic [12:0] pylenbit,
   input  logic        crcencode,
   input  logic        fec31encode,
   input  logic        fec32encode,
   output logic        busy,
   output logic [1:0]  src_sel,
   output logic        data_rd_p,
   output logic        crc_shift_p,
   output logic        par_shift_p,
   output logic        done_p,
   output logic [14:0] airbitcnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DATA   = 3'd1;
   localparam logic [2:0] S_CRC    = 3'd2;
   localparam logic [2:0] S_PAD    = 3'd3;
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic [2:0] S_FIN    = 3'd5;

   logic [2:0]  state;
   logic [12:0] len_r;
   logic        crc_r, f31_r, f32_r;
   logic [12:0] datacnt;
   logic [4:0]  crccnt;
   logic [1:0]  repcnt;
   logic [3:0]  blkcnt;
   logic [2:0]  parcnt;

   logic        bit_ok, last_rep, is_info;
   logic [12:0] d_n;
   logic [4:0]  c_n;
   logic [2:0]  info_nxt, ret_nxt;

   // Where the info stream continues given consumed data/CRC counts.
   function automatic logic [2:0] info_state(input logic [12:0] d, input logic [4:0] c,
                                             input logic [12:0] len, input logic crc);
      if (d < len)                 info_state = S_DATA;
      else if (crc && c < 5'd16)   info_state = S_CRC;
      else                         info_state = S_FIN;
   endfunction

   always_comb begin
      bit_ok   = bit_p & ~start_p & ~abort_p;
      last_rep = ~f31_r | (repcnt == 2'd2);
      is_info  = (state == S_DATA) | (state == S_CRC);
      d_n      = datacnt + 13'(state == S_DATA);
      c_n      = crccnt + 5'(state == S_CRC);
      info_nxt = info_state(d_n, c_n, len_r, crc_r);
      ret_nxt  = info_state(datacnt, crccnt, len_r, crc_r);
   end

   always_comb begin
      src_sel = 2'd0;
      case (state)
         S_CRC:    src_sel = 2'd1;
         S_PAD:    src_sel = 2'd2;
         S_PARITY: src_sel = 2'd3;
         default:  src_sel = 2'd0;
      endcase
   end

   assign busy        = (state != S_IDLE);
   assign data_rd_p   = bit_ok & (state == S_DATA) & last_rep;
   assign crc_shift_p = bit_ok & (state == S_CRC) & last_rep;
   assign par_shift_p = bit_ok & (state == S_PARITY);
   assign done_p      = (state == S_FIN) & ~abort_p;

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         len_r     <= '0;
         crc_r     <= 1'b0;
         f31_r     <= 1'b0;
         f32_r     <= 1'b0;
         datacnt   <= '0;
         crccnt    <= '0;
         repcnt    <= '0;
         blkcnt    <= '0;
         parcnt    <= '0;
         airbitcnt <= '0;
      end else if (abort_p) begin
         state <= S_IDLE;
      end else if (start_p) begin
         len_r     <= pylenbit;
         crc_r     <= crcencode;
         f31_r     <= fec31encode;
         f32_r     <= fec32encode & ~fec31encode;
         datacnt   <= '0;
         crccnt    <= '0;
         repcnt    <= '0;
         blkcnt    <= '0;
         parcnt    <= '0;
         airbitcnt <= '0;
         state     <= (pylenbit == 13'd0) ? S_FIN : S_DATA;
      end else if (state == S_FIN) begin
         state <= S_IDLE;
      end else if (bit_ok && state != S_IDLE) begin
         airbitcnt <= airbitcnt + 15'd1;
         if (is_info) begin
            if (!last_rep) begin
               repcnt <= repcnt + 2'd1;
            end else begin
               repcnt  <= '0;
               datacnt <= d_n;
               crccnt  <= c_n;
               if (f32_r) begin
                  // A full block of 10 info bits always hands over to parity;
                  // otherwise running out of info mid-block means zero padding.
                  if (blkcnt == 4'd9) begin
                     blkcnt <= '0;
                     state  <= S_PARITY;
                  end else begin
                     blkcnt <= blkcnt + 4'd1;
                     state  <= (info_nxt == S_FIN) ? S_PAD : info_nxt;
                  end
               end else begin
                  state <= info_nxt;
               end
            end
         end else if (state == S_PAD) begin
            if (blkcnt == 4'd9) begin
               blkcnt <= '0;
               state  <= S_PARITY;
            end else begin
               blkcnt <= blkcnt + 4'd1;
            end
         end else if (state == S_PARITY) begin
            if (parcnt == 3'd4) begin
               parcnt <= '0;
               state  <= ret_nxt;
            end else begin
               parcnt <= parcnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pybitseq.sv
// Randomized scoreboard bench for pybitseq: a list-based air-bit model feeds
// expectations to a monitor that checks every accepted bit_p.
module tb_pybitseq;

   typedef struct packed {
      logic [1:0] src;
      logic       d;
      logic       c;
      logic       p;
   } air_t;

   logic        clk_6M = 1'b0;
   logic        rst = 1'b1;
   logic        start_p = 1'b0, abort_p = 1'b0, bit_p = 1'b0;
   logic [12:0] pylenbit = '0;
   logic        crcencode = 1'b0, fec31encode = 1'b0, fec32encode = 1'b0;
   logic        busy, data_rd_p, crc_shift_p, par_shift_p, done_p;
   logic [1:0]  src_sel;
   logic [14:0] airbitcnt;

   int checks = 0, errors = 0;
   int n_data = 0, n_crc = 0, n_par = 0, n_done = 0;
   air_t sb[$];

   pybitseq dut (
      .clk_6M(clk_6M), .rst(rst), .start_p(start_p), .abort_p(abort_p), .bit_p(bit_p),
      .pylenbit(pylenbit), .crcencode(crcencode), .fec31encode(fec31encode),
      .fec32encode(fec32encode), .busy(busy), .src_sel(src_sel), .data_rd_p(data_rd_p),
      .crc_shift_p(crc_shift_p), .par_shift_p(par_shift_p), .done_p(done_p),
      .airbitcnt(airbitcnt)
   );

   always #83 clk_6M = ~clk_6M;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per accepted air bit.
   always @(negedge clk_6M) begin
      if (!rst) begin
         n_data += int'(data_rd_p);
         n_crc  += int'(crc_shift_p);
         n_par  += int'(par_shift_p);
         n_done += int'(done_p);
         if (bit_p && !start_p && !abort_p && busy && !done_p) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_bit", 1, 0);
            end else begin
               air_t e;
               e = sb.pop_front();
               chk("src_sel", int'(src_sel), int'(e.src));
               chk("data_rd_p", int'(data_rd_p), int'(e.d));
               chk("crc_shift_p", int'(crc_shift_p), int'(e.c));
               chk("par_shift_p", int'(par_shift_p), int'(e.p));
            end
         end else begin
            chk("idle_strobes", int'({data_rd_p, crc_shift_p, par_shift_p}), 0);
         end
      end
   end

   // Reference sequence built from the framing rules, not the RTL states.
   task automatic build(input int L, input bit crc, input bit f31, input bit f32,
                        output air_t air[$]);
      air_t info[$];
      air_t a;
      int   I;
      air = {};
      I = L + (crc ? 16 : 0);
      for (int i = 0; i < I; i++) begin
         a.src = (i < L) ? 2'd0 : 2'd1;
         a.d = (i < L); a.c = (i >= L); a.p = 1'b0;
         info.push_back(a);
      end
      if (f31) begin
         foreach (info[i]) begin
            a = info[i]; a.d = 1'b0; a.c = 1'b0;
            air.push_back(a); air.push_back(a); air.push_back(info[i]);
         end
      end else if (f32) begin
         for (int b = 0; b < (I + 9) / 10; b++) begin
            for (int j = 0; j < 10; j++) begin
               if (b * 10 + j < I) air.push_back(info[b * 10 + j]);
               else begin a = '0; a.src = 2'd2; air.push_back(a); end
            end
            for (int j = 0; j < 5; j++) begin a = '0; a.src = 2'd3; a.p = 1'b1; air.push_back(a); end
         end
      end else begin
         air = info;
      end
   endtask

   // mode 0: run to completion, 1: abort after stop_at bits, 2: abandon after stop_at bits
   task automatic run(input int L, input bit crc, input bit f31, input bit f32,
                      input int stop_at, input int mode);
      air_t air[$];
      int I, total, n, d0, c0, p0, k0;
      build(L, crc, f31, f32, air);
      I = L + (crc ? 16 : 0);
      total = f31 ? 3 * I : (f32 ? 15 * ((I + 9) / 10) : I);
      if (L == 0) total = 0;
      d0 = n_data; c0 = n_crc; p0 = n_par; k0 = n_done;
      @(posedge clk_6M); #1;
      start_p = 1'b1; pylenbit = 13'(L); crcencode = crc; fec31encode = f31; fec32encode = f32;
      @(posedge clk_6M); #1;
      start_p = 1'b0;
      pylenbit = 13'($urandom); crcencode = 1'($urandom); fec31encode = 1'($urandom);
      fec32encode = 1'($urandom);
      if (L == 0) begin
         @(negedge clk_6M);
         chk("null_done", int'(done_p), 1);
         chk("null_busy_n1", int'(busy), 1);
         chk("null_airbitcnt", int'(airbitcnt), 0);
         @(posedge clk_6M); #1;
         @(negedge clk_6M);
         chk("null_busy_n2", int'(busy), 0);
         chk("null_done_count", n_done - k0, 1);
         return;
      end
      n = (mode == 0) ? air.size() : stop_at;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk_6M); #1; end
         sb.push_back(air[i]);
         bit_p = 1'b1;
         @(posedge clk_6M); #1;
         bit_p = 1'b0;
      end
      if (mode == 0) begin
         @(negedge clk_6M);
         chk("done_p", int'(done_p), 1);
         chk("airbitcnt_total", int'(airbitcnt), total);
         @(posedge clk_6M); #1;
         @(negedge clk_6M);
         chk("busy_after_done", int'(busy), 0);
         chk("done_count", n_done - k0, 1);
         chk("data_count", n_data - d0, L);
         chk("crc_count", n_crc - c0, crc ? 16 : 0);
         chk("par_count", n_par - p0, (f32 && !f31) ? 5 * ((I + 9) / 10) : 0);
         chk("sb_drained", sb.size(), 0);
      end else if (mode == 1) begin
         abort_p = 1'b1;
         @(posedge clk_6M); #1;
         abort_p = 1'b0;
         @(negedge clk_6M);
         chk("abort_busy", int'(busy), 0);
         chk("abort_airbitcnt", int'(airbitcnt), stop_at);
         chk("abort_no_done", n_done - k0, 0);
      end
   endtask

   initial begin
      #10;
      chk("rst_busy", int'(busy), 0);
      chk("rst_outputs", int'({src_sel, data_rd_p, crc_shift_p, par_shift_p, done_p}), 0);
      chk("rst_airbitcnt", int'(airbitcnt), 0);
      @(posedge clk_6M); #1;
      rst = 1'b0;

      run(144, 1, 0, 1, 0, 0);           // DM1-like
      run(8,   1, 0, 1, 0, 0);           // short fec32 with padding
      run(80,  0, 1, 0, 0, 0);           // HV1-like
      run(0,   1, 1, 0, 0, 0);           // NULL
      run(224, 1, 0, 0, 100, 1);         // DH1-like, abort after 100
      run(224, 1, 0, 0, 0, 0);           // DH1-like restart
      run(4,   0, 0, 1, 0, 0);           // fec32, exact block boundary after 10? no: 4 bits
      run(14,  1, 0, 1, 0, 0);           // I=30: exact boundary, no pad
      run(7,   1, 1, 1, 0, 0);           // fec31 wins over fec32

      // start_p together with bit_p: bit ignored
      @(posedge clk_6M); #1;
      start_p = 1'b1; bit_p = 1'b1; pylenbit = 13'd20; crcencode = 0; fec31encode = 0; fec32encode = 0;
      @(posedge clk_6M); #1;
      start_p = 1'b0; bit_p = 1'b0;
      @(negedge clk_6M);
      chk("start_bit_airbitcnt", int'(airbitcnt), 0);
      chk("start_bit_busy", int'(busy), 1);

      // mid-payload restart with a new config
      run(50, 0, 0, 1, 23, 2);
      run(33, 1, 0, 1, 0, 0);

      // abort together with start: abort wins
      run(40, 0, 1, 0, 10, 2);
      @(posedge clk_6M); #1;
      abort_p = 1'b1; start_p = 1'b1; pylenbit = 13'd9;
      @(posedge clk_6M); #1;
      abort_p = 1'b0; start_p = 1'b0;
      @(negedge clk_6M);
      chk("abort_start_busy", int'(busy), 0);

      for (int r = 0; r < 12; r++) begin
         int L;
         L = $urandom_range(0, 60);
         run(L, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
